axi4_lite_master: RTL and testbench

- AXI4-Lite initiator for the team's 8-word AXI4-Lite register slave; converts single-beat local commands into AW/W/B or AR/R channel transactions.
- Sits between a local controller (CPU stub, test sequencer) and the AXI4-Lite slave port.
- One outstanding transaction at a time; reports the slave response and read data back on a single-cycle response strobe.

---
 rtl/axi4_lite_master.sv | 274 +++++++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite initiator.
// Turns one local command (read or write) into an AR/R or AW/W/B exchange
// and reports completion on a one-cycle response strobe.
// Optional build macro AXI_MASTER_TIMEOUT_EN adds a per-state watchdog that
// aborts a stalled transaction after TIMEOUT_CYCLES cycles with response 2'b11.
module axi4_lite_master #(
    parameter int addr_width     = 3,
    parameter int data_width     = 32,
    parameter int strb_width     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // local command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    input  logic [strb_width-1:0] cmd_wstrb,
    // local response side
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [data_width-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // write address channel
    output logic                  awvalid,
    input  logic                  awready,
    output logic [addr_width-1:0] awaddr,
    output logic                  awprot,
    // write data channel
    output logic                  wvalid,
    input  logic                  wready,
    output logic [data_width-1:0] wdata,
    output logic [strb_width-1:0] wstrb,
    // write response channel
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    // read address channel
    output logic                  arvalid,
    input  logic                  arready,
    output logic [addr_width-1:0] araddr,
    output logic                  arprot,
    // read data channel
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [data_width-1:0] rdata,
    input  logic [1:0]            rresp
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            r_state, r_state_next;
    logic                  r_cmd_ready, r_cmd_ready_next;
    logic                  r_awvalid, r_awvalid_next;
    logic                  r_wvalid, r_wvalid_next;
    logic                  r_bready, r_bready_next;
    logic                  r_arvalid, r_arvalid_next;
    logic                  r_rready, r_rready_next;
    logic                  r_rsp_valid, r_rsp_valid_next;
    logic                  r_rsp_write, r_rsp_write_next;
    logic [1:0]            r_rsp_resp, r_rsp_resp_next;
    logic [data_width-1:0] r_rsp_rdata, r_rsp_rdata_next;
    logic [addr_width-1:0] r_addr, r_addr_next;
    logic [data_width-1:0] r_wdata, r_wdata_next;
    logic [strb_width-1:0] r_wstrb, r_wstrb_next;

    logic w_accept;
    logic w_aw_done;
    logic w_w_done;
    logic w_timeout;
    logic w_in_write;

    assign w_accept   = r_cmd_ready & cmd_valid;
    // A channel counts as done once its valid has already dropped or it handshakes now.
    assign w_aw_done  = ~r_awvalid | awready;
    assign w_w_done   = ~r_wvalid | wready;
    assign w_in_write = (r_state == S_WR_REQ) || (r_state == S_WR_RESP);

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer, r_timer_next;
    logic          w_waiting;

    assign w_waiting = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                       (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
    // The count reaches TIMEOUT_CYCLES on the cycle that would take it there.
    assign w_timeout = w_waiting && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: restarts on every state change, counts while waiting on the slave.
    always_comb begin
        r_timer_next = '0;
        if (r_state_next == r_state && w_waiting) begin
            r_timer_next = r_timer + TW'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer_next;
        end
    end
`else
    // Watchdog compiled out: the master waits on the slave indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        r_state_next     = r_state;
        r_cmd_ready_next = r_cmd_ready;
        r_awvalid_next   = r_awvalid;
        r_wvalid_next    = r_wvalid;
        r_bready_next    = r_bready;
        r_arvalid_next   = r_arvalid;
        r_rready_next    = r_rready;
        r_rsp_valid_next = 1'b0;
        r_rsp_write_next = r_rsp_write;
        r_rsp_resp_next  = r_rsp_resp;
        r_rsp_rdata_next = r_rsp_rdata;
        r_addr_next      = r_addr;
        r_wdata_next     = r_wdata;
        r_wstrb_next     = r_wstrb;

        case (r_state)
            S_IDLE: begin
                r_cmd_ready_next = 1'b1;
                if (w_accept) begin
                    r_cmd_ready_next = 1'b0;
                    r_addr_next      = cmd_addr;
                    r_wdata_next     = cmd_wdata;
                    r_wstrb_next     = cmd_wstrb;
                    if (cmd_write) begin
                        r_awvalid_next = 1'b1;
                        r_wvalid_next  = 1'b1;
                        r_state_next   = S_WR_REQ;
                    end else begin
                        r_arvalid_next = 1'b1;
                        r_state_next   = S_RD_ADDR;
                    end
                end
            end
            S_WR_REQ: begin
                if (r_awvalid && awready) begin
                    r_awvalid_next = 1'b0;
                end
                if (r_wvalid && wready) begin
                    r_wvalid_next = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    r_bready_next = 1'b1;
                    r_state_next  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    r_bready_next    = 1'b0;
                    r_rsp_valid_next = 1'b1;
                    r_rsp_write_next = 1'b1;
                    r_rsp_resp_next  = bresp;
                    r_rsp_rdata_next = '0;
                    r_state_next     = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (arready) begin
                    r_arvalid_next = 1'b0;
                    r_rready_next  = 1'b1;
                    r_state_next   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    r_rready_next    = 1'b0;
                    r_rsp_valid_next = 1'b1;
                    r_rsp_write_next = 1'b0;
                    r_rsp_resp_next  = rresp;
                    r_rsp_rdata_next = rdata;
                    r_state_next     = S_DONE;
                end
            end
            S_DONE: begin
                r_cmd_ready_next = 1'b1;
                r_state_next     = S_IDLE;
            end
            default: begin
                r_cmd_ready_next = 1'b1;
                r_awvalid_next   = 1'b0;
                r_wvalid_next    = 1'b0;
                r_bready_next    = 1'b0;
                r_arvalid_next   = 1'b0;
                r_rready_next    = 1'b0;
                r_state_next     = S_IDLE;
            end
        endcase

        // Watchdog abort: a completed handshake in the same cycle takes priority.
        if (w_timeout && (r_state_next == r_state)) begin
            r_awvalid_next   = 1'b0;
            r_wvalid_next    = 1'b0;
            r_bready_next    = 1'b0;
            r_arvalid_next   = 1'b0;
            r_rready_next    = 1'b0;
            r_rsp_valid_next = 1'b1;
            r_rsp_write_next = w_in_write;
            r_rsp_resp_next  = 2'b11;
            r_rsp_rdata_next = '0;
            r_state_next     = S_DONE;
        end
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_resp  <= 2'b00;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            r_state     <= r_state_next;
            r_cmd_ready <= r_cmd_ready_next;
            r_awvalid   <= r_awvalid_next;
            r_wvalid    <= r_wvalid_next;
            r_bready    <= r_bready_next;
            r_arvalid   <= r_arvalid_next;
            r_rready    <= r_rready_next;
            r_rsp_valid <= r_rsp_valid_next;
            r_rsp_write <= r_rsp_write_next;
            r_rsp_resp  <= r_rsp_resp_next;
            r_rsp_rdata <= r_rsp_rdata_next;
            r_addr      <= r_addr_next;
            r_wdata     <= r_wdata_next;
            r_wstrb     <= r_wstrb_next;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign awvalid   = r_awvalid;
    assign awaddr    = r_addr;
    assign awprot    = 1'b0;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign bready    = r_bready;
    assign arvalid   = r_arvalid;
    assign araddr    = r_addr;
    assign arprot    = 1'b0;
    assign rready    = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Testbench for axi4_lite_master: an 8-word AXI4-Lite slave with programmable
// per-channel delays drives the master; a reference memory and the timing
// rules of the protocol give the expected response, latency and cycle counts.
module tb_axi4_lite_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, awprot;
    logic [2:0]  awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready, arprot;
    logic [2:0]  araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    axi4_lite_master #(
        .addr_width(3), .data_width(32), .strb_width(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 aclk = ~aclk;

    // ---------------- slave with programmable delays ----------------
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic [1:0]  cfg_bresp, cfg_rresp;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic        got_aw, got_w, pend_b, pend_r;
    logic [2:0]  s_waddr, s_raddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [8];

    logic        s_aw_hs, s_w_hs, s_ha, s_hw;
    logic [2:0]  s_a;
    logic [31:0] s_d;
    logic [3:0]  s_s;

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid && (w_wait >= w_delay);
    assign bvalid  = pend_b && (b_wait >= b_delay);
    assign bresp   = cfg_bresp;
    assign arready = arvalid && (ar_wait >= ar_delay);
    assign rvalid  = pend_r && (r_wait >= r_delay);
    assign rdata   = rvalid ? mem[s_raddr] : 32'h0;
    assign rresp   = cfg_rresp;

    assign s_aw_hs = awvalid && awready;
    assign s_w_hs  = wvalid && wready;
    assign s_ha    = got_aw || s_aw_hs;
    assign s_hw    = got_w || s_w_hs;
    assign s_a     = s_aw_hs ? awaddr : s_waddr;
    assign s_d     = s_w_hs ? wdata : s_wdata;
    assign s_s     = s_w_hs ? wstrb : s_wstrb;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; pend_b <= 1'b0; pend_r <= 1'b0;
            s_waddr <= '0; s_raddr <= '0; s_wdata <= '0; s_wstrb <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            b_wait  <= (pend_b && !(bvalid && bready)) ? b_wait + 1 : 0;
            r_wait  <= (pend_r && !(rvalid && rready)) ? r_wait + 1 : 0;
            if (bvalid && bready) pend_b <= 1'b0;
            if (rvalid && rready) pend_r <= 1'b0;
            if (s_aw_hs) begin got_aw <= 1'b1; s_waddr <= awaddr; end
            if (s_w_hs) begin got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
            if (s_ha && s_hw) begin
                for (int b = 0; b < 4; b++)
                    if (s_s[b]) mem[s_a][8*b +: 8] <= s_d[8*b +: 8];
                got_aw <= 1'b0; got_w <= 1'b0; pend_b <= 1'b1; b_wait <= 0;
            end
            if (arvalid && arready) begin pend_r <= 1'b1; s_raddr <= araddr; r_wait <= 0; end
        end
    end

    // ---------------- channel activity monitor ----------------
    logic [2:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int n_aw_cyc = 0, n_w_cyc = 0, n_ar_cyc = 0, n_b_cyc = 0, n_r_cyc = 0;
    int n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0, n_r_hs = 0;
    int n_rsp = 0, n_stab = 0;

    always @(posedge aclk) begin
        n_aw_cyc <= n_aw_cyc + int'(awvalid);
        n_w_cyc  <= n_w_cyc + int'(wvalid);
        n_ar_cyc <= n_ar_cyc + int'(arvalid);
        n_b_cyc  <= n_b_cyc + int'(bready);
        n_r_cyc  <= n_r_cyc + int'(rready);
        n_aw_hs  <= n_aw_hs + int'(awvalid && awready);
        n_w_hs   <= n_w_hs + int'(wvalid && wready);
        n_b_hs   <= n_b_hs + int'(bvalid && bready);
        n_ar_hs  <= n_ar_hs + int'(arvalid && arready);
        n_r_hs   <= n_r_hs + int'(rvalid && rready);
        n_rsp    <= n_rsp + int'(rsp_valid);
        n_stab   <= n_stab + int'((awvalid && awaddr !== exp_addr) ||
                                  (wvalid && (wdata !== exp_wdata || wstrb !== exp_wstrb)) ||
                                  (arvalid && araddr !== exp_addr));
    end

    // ---------------- checking helpers and reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] ref_mem [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic wait_cmd_ready();
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin @(negedge aclk); t++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    endtask

    // One command through the master, checked against the reference memory
    // and the protocol's timing rules for the current slave delays.
    task automatic run_cmd(input logic w, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        int lat, exp_lat;
        int c_aw, c_w, c_ar, c_b, c_r, h_aw, h_w, h_b, h_ar, h_r, c_rsp, c_stab;
        logic busy_ok;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;

        wait_cmd_ready();
        exp_addr = a; exp_wdata = d; exp_wstrb = s;
        if (w) begin
            exp_rdata = 32'h0; exp_resp = cfg_bresp;
            exp_lat = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
        end else begin
            exp_rdata = ref_mem[a]; exp_resp = cfg_rresp;
            exp_lat = 3 + ar_delay + r_delay;
        end
        c_aw = n_aw_cyc; c_w = n_w_cyc; c_ar = n_ar_cyc; c_b = n_b_cyc; c_r = n_r_cyc;
        h_aw = n_aw_hs; h_w = n_w_hs; h_b = n_b_hs; h_ar = n_ar_hs; h_r = n_r_hs;
        c_rsp = n_rsp; c_stab = n_stab;

        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge aclk);
        #1;
        // Keep presenting junk commands while busy; they must be ignored.
        cmd_write = 1'($urandom); cmd_addr = 3'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        lat = 0; busy_ok = 1'b1;
        do begin
            @(negedge aclk);
            lat++;
            if (!rsp_valid && cmd_ready) busy_ok = 1'b0;
        end while (!rsp_valid && lat < 200);
        cmd_valid = 1'b0;

        $display("txn %s addr=%0d wdata=%08h wstrb=%h -> resp=%0d rdata=%08h lat=%0d",
                 w ? "WR" : "RD", a, d, s, rsp_resp, rsp_rdata, lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("cmd_ready_low_busy", 64'(busy_ok), 64'(1));
        chk("rsp_write", 64'(rsp_write), 64'(w));
        chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        @(negedge aclk);
        chk("rsp_pulse", 64'({rsp_valid, cmd_ready, 8'(n_rsp - c_rsp)}), 64'({1'b0, 1'b1, 8'd1}));
        chk("payload_stable", 64'(n_stab - c_stab), 64'(0));
        if (w) begin
            chk("wr_handshakes", 64'({8'(n_aw_hs - h_aw), 8'(n_w_hs - h_w), 8'(n_b_hs - h_b),
                                      8'(n_ar_hs - h_ar), 8'(n_r_hs - h_r)}),
                                 64'({8'd1, 8'd1, 8'd1, 8'd0, 8'd0}));
            chk("wr_valid_cycles", 64'({16'(n_aw_cyc - c_aw), 16'(n_w_cyc - c_w), 16'(n_b_cyc - c_b)}),
                                   64'({16'(aw_delay + 1), 16'(w_delay + 1), 16'(b_delay + 1)}));
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            chk("rd_handshakes", 64'({8'(n_aw_hs - h_aw), 8'(n_w_hs - h_w), 8'(n_b_hs - h_b),
                                      8'(n_ar_hs - h_ar), 8'(n_r_hs - h_r)}),
                                 64'({8'd0, 8'd0, 8'd0, 8'd1, 8'd1}));
            chk("rd_valid_cycles", 64'({16'(n_ar_cyc - c_ar), 16'(n_r_cyc - c_r)}),
                                   64'({16'(ar_delay + 1), 16'(r_delay + 1)}));
        end
    endtask

    task automatic set_delays(input int aw, input int wd, input int bd, input int ard, input int rd);
        aw_delay = aw; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int t;
        logic [2:0]  ra;
        logic [31:0] rd;
        logic [3:0]  rs;
        logic        rw;

        aresetn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        set_delays(0, 0, 0, 0, 0);
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
        repeat (3) @(negedge aclk);
        chk("reset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write,
                               cmd_ready, awprot, arprot, awaddr, araddr, rsp_resp, wstrb}), 64'(0));
        chk("reset_data", {wdata, rsp_rdata}, 64'(0));
        aresetn = 1'b1;
        @(negedge aclk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

        // Fill every word so the reference and slave memories start identical.
        for (int i = 0; i < 8; i++)
            run_cmd(1'b1, 3'(i), 32'hA5000000 + 32'(i * 32'h00010203), 4'hF);
        run_cmd(1'b1, 3'd5, 32'hFFFFFFFF, 4'hF);

        // Write with an always-ready slave, then read it back.
        run_cmd(1'b1, 3'd3, 32'hDEADBEEF, 4'hF);
        run_cmd(1'b0, 3'd3, 32'h0, 4'h0);
        chk("readback_deadbeef", 64'(rsp_rdata), 64'(32'hDEADBEEF));

        // AW handshake three cycles late, W immediate.
        set_delays(3, 0, 0, 0, 0);
        run_cmd(1'b1, 3'd1, 32'h0BADF00D, 4'hF);
        set_delays(0, 0, 0, 0, 0);

        // Partial strobe merge.
        run_cmd(1'b1, 3'd5, 32'h11223344, 4'b0101);
        run_cmd(1'b0, 3'd5, 32'h0, 4'h0);
        chk("partial_strobe", 64'(rsp_rdata), 64'(32'hFF22FF44));

        // Slow read with SLVERR.
        set_delays(0, 0, 0, 0, 5);
        cfg_rresp = 2'b10;
        run_cmd(1'b0, 3'd3, 32'h0, 4'h0);
        cfg_rresp = 2'b00;

        // Random transactions with random slave delays and responses.
        for (int i = 0; i < 24; i++) begin
            set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            cfg_bresp = 2'($urandom_range(0, 3));
            cfg_rresp = 2'($urandom_range(0, 3));
            rw = 1'($urandom); ra = 3'($urandom); rd = $urandom; rs = 4'($urandom);
            run_cmd(rw, ra, rd, rs);
        end
        set_delays(0, 0, 0, 0, 0);
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;

        // Reset while waiting for B: the slave has already committed the write.
        b_delay = 1000;
        wait_cmd_ready();
        exp_addr = 3'd6; exp_wdata = 32'hCAFEF00D; exp_wstrb = 4'hF;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd6; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        t = 0;
        while (bready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
        chk("bready_before_reset", 64'(bready), 64'(1));
        ref_mem[6] = 32'hCAFEF00D;
        #2 aresetn = 1'b0;
        #1;
        $display("txn RESET mid-write");
        chk("midreset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write,
                                  cmd_ready, awprot, arprot, awaddr, araddr, rsp_resp, wstrb}), 64'(0));
        chk("midreset_data", {wdata, rsp_rdata}, 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        b_delay = 0;
        @(negedge aclk);
        chk("cmd_ready_after_midreset", 64'(cmd_ready), 64'(1));
        run_cmd(1'b0, 3'd3, 32'h0, 4'h0);
        run_cmd(1'b0, 3'd6, 32'h0, 4'h0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // AR never accepted: watchdog aborts after eight cycles.
        begin
            int c_ar, h_ar;
            ar_delay = 1000;
            wait_cmd_ready();
            exp_addr = 3'd2;
            c_ar = n_ar_cyc; h_ar = n_ar_hs;
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2;
            @(posedge aclk);
            #1 cmd_valid = 1'b0;
            t = 0;
            while (rsp_valid !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
            $display("txn RD addr=2 timeout -> resp=%0d rdata=%08h", rsp_resp, rsp_rdata);
            chk("timeout_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("timeout_resp", 64'(rsp_resp), 64'(2'b11));
            chk("timeout_rdata", 64'(rsp_rdata), 64'(0));
            @(negedge aclk);
            chk("timeout_arvalid_cycles", 64'({16'(n_ar_cyc - c_ar), 16'(n_ar_hs - h_ar)}),
                                          64'({16'd8, 16'd0}));
            ar_delay = 0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
